// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, drives instruction-memory fetches over a req/ready
// handshake, and picks the next PC from PC+4, branch or jump targets.
module fetch_sequencer #(
    parameter int                       ADDRESS_WIDTH = 32,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = 32'h0000_0000,
    parameter int                       WAIT_WIDTH    = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     stall,
    input  logic                     branch_taken,
    input  logic [ADDRESS_WIDTH-1:0] branch_target,
    input  logic                     jump,
    input  logic [ADDRESS_WIDTH-1:0] jump_target,
    output logic                     imem_req,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic                     imem_ready,
    output logic                     instr_valid,
    output logic [ADDRESS_WIDTH-1:0] instr_pc,
    output logic [ADDRESS_WIDTH-1:0] PC,
    output logic                     timeout_err
);

    typedef enum logic [1:0] {
        RESET,
        FETCH,
        STALL,
        ERROR
    } state_t;

    localparam logic [WAIT_WIDTH-1:0] WAIT_MAX = {WAIT_WIDTH{1'b1}};

    state_t                   state;
    logic [WAIT_WIDTH-1:0]    wait_cnt;
    logic                     pending_valid;
    logic [ADDRESS_WIDTH-1:0] pending_target;
    logic                     flush;

    logic                     redirect_any;
    logic [ADDRESS_WIDTH-1:0] redirect_raw;
    logic [ADDRESS_WIDTH-1:0] redirect_target;
    logic [ADDRESS_WIDTH-1:0] pc_plus4;
    logic [ADDRESS_WIDTH-1:0] next_pc;

    assign redirect_any    = jump | branch_taken;
    assign redirect_raw    = jump ? jump_target : branch_target;
    assign redirect_target = redirect_raw & ~ADDRESS_WIDTH'(3);
    assign pc_plus4        = PC + ADDRESS_WIDTH'(4);

    // A redirect arriving this cycle beats one latched while the fetch was waiting
    always_comb begin
        next_pc = pc_plus4;
        if (redirect_any) begin
            next_pc = redirect_target;
        end else if (pending_valid) begin
            next_pc = pending_target;
        end
    end

    assign imem_req  = (state == FETCH);
    assign imem_addr = PC;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state          <= RESET;
            PC             <= RESET_VECTOR;
            instr_pc       <= RESET_VECTOR;
            instr_valid    <= 1'b0;
            timeout_err    <= 1'b0;
            wait_cnt       <= '0;
            pending_valid  <= 1'b0;
            pending_target <= '0;
            flush          <= 1'b0;
        end else begin
            instr_valid <= 1'b0;
            unique case (state)
                RESET: begin
                    state <= stall ? STALL : FETCH;
                end
                FETCH: begin
                    if (imem_ready) begin
                        PC            <= next_pc;
                        instr_pc      <= PC;
                        instr_valid   <= !flush && !redirect_any;
                        wait_cnt      <= '0;
                        flush         <= 1'b0;
                        pending_valid <= 1'b0;
                        state         <= stall ? STALL : FETCH;
                    end else begin
                        // The request stays on the bus; its result is dropped on acceptance
                        if (redirect_any) begin
                            pending_valid  <= 1'b1;
                            pending_target <= redirect_target;
                            flush          <= 1'b1;
                        end
                        if (wait_cnt == WAIT_MAX) begin
                            state       <= ERROR;
                            timeout_err <= 1'b1;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                end
                STALL: begin
                    if (redirect_any) begin
                        PC <= redirect_target;
                    end
                    if (!stall) begin
                        state <= FETCH;
                    end
                end
                ERROR: begin
                    timeout_err <= 1'b1;
                end
                default: state <= RESET;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: run, wait states, redirects, stall priority,
// timeout, reset mid-fetch and PC wraparound.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        instr_valid;
    logic [31:0] instr_pc;
    logic [31:0] pc;
    logic        timeout_err;

    logic        rst_wrap;
    logic        ready_wrap;
    logic        req_wrap;
    logic [31:0] addr_wrap;
    logic        valid_wrap;
    logic [31:0] instr_pc_wrap;
    logic [31:0] pc_wrap;
    logic        timeout_wrap;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    fetch_sequencer #(
        .ADDRESS_WIDTH(32),
        .RESET_VECTOR (32'h0000_0000),
        .WAIT_WIDTH   (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .instr_valid  (instr_valid),
        .instr_pc     (instr_pc),
        .PC           (pc),
        .timeout_err  (timeout_err)
    );

    // Second instance exercises the PC+4 wrap from the top of the address space
    fetch_sequencer #(
        .ADDRESS_WIDTH(32),
        .RESET_VECTOR (32'hFFFF_FFFC),
        .WAIT_WIDTH   (4)
    ) dut_wrap (
        .clk          (clk),
        .rst          (rst_wrap),
        .stall        (1'b0),
        .branch_taken (1'b0),
        .branch_target(32'h0),
        .jump         (1'b0),
        .jump_target  (32'h0),
        .imem_req     (req_wrap),
        .imem_addr    (addr_wrap),
        .imem_ready   (ready_wrap),
        .instr_valid  (valid_wrap),
        .instr_pc     (instr_pc_wrap),
        .PC           (pc_wrap),
        .timeout_err  (timeout_wrap)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int cycles);
        repeat (cycles) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst           = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = '0;
        jump          = 1'b0;
        jump_target   = '0;
        imem_ready    = 1'b1;
        rst_wrap      = 1'b0;
        ready_wrap    = 1'b1;

        applyStimulus(1);
        checkOutput("rst_req_1", imem_req, 1'b0);
        applyStimulus(1);
        checkOutput("rst_req_2", imem_req, 1'b0);
        checkOutput("rst_pc", pc, 32'h0);
        checkOutput("rst_valid", instr_valid, 1'b0);
        checkOutput("rst_timeout", timeout_err, 1'b0);

        rst = 1'b1;
        applyStimulus(1);
        checkOutput("reset_cycle_req", imem_req, 1'b1);
        checkOutput("reset_cycle_valid", instr_valid, 1'b0);
        checkOutput("reset_cycle_pc", pc, 32'h0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1);
            checkOutput("run_valid", instr_valid, 1'b1);
            checkOutput("run_instr_pc", instr_pc, 32'(4 * i));
        end
        checkOutput("run_pc", pc, 32'h10);

        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1);
            checkOutput("wait_req", imem_req, 1'b1);
            checkOutput("wait_addr", imem_addr, 32'h10);
            checkOutput("wait_valid", instr_valid, 1'b0);
        end
        imem_ready = 1'b1;
        applyStimulus(1);
        checkOutput("wait_done_valid", instr_valid, 1'b1);
        checkOutput("wait_done_instr_pc", instr_pc, 32'h10);
        checkOutput("wait_done_pc", pc, 32'h14);

        applyStimulus(3);
        checkOutput("pre_redirect_pc", pc, 32'h20);
        imem_ready = 1'b0;
        applyStimulus(1);
        branch_taken  = 1'b1;
        branch_target = 32'h101;
        applyStimulus(1);
        checkOutput("redirect_req", imem_req, 1'b1);
        checkOutput("redirect_addr", imem_addr, 32'h20);
        branch_taken = 1'b0;
        jump         = 1'b1;
        jump_target  = 32'h200;
        applyStimulus(1);
        checkOutput("redirect_addr_2", imem_addr, 32'h20);
        jump       = 1'b0;
        imem_ready = 1'b1;
        applyStimulus(1);
        checkOutput("flush_valid", instr_valid, 1'b0);
        checkOutput("flush_pc", pc, 32'h200);
        applyStimulus(1);
        checkOutput("post_flush_valid", instr_valid, 1'b1);
        checkOutput("post_flush_instr_pc", instr_pc, 32'h200);
        checkOutput("post_flush_pc", pc, 32'h204);

        stall = 1'b1;
        applyStimulus(1);
        checkOutput("stall_enter_req", imem_req, 1'b0);
        checkOutput("stall_enter_pc", pc, 32'h208);
        jump          = 1'b1;
        jump_target   = 32'h83;
        branch_taken  = 1'b1;
        branch_target = 32'h40;
        applyStimulus(1);
        checkOutput("stall_prio_pc", pc, 32'h80);
        checkOutput("stall_prio_req", imem_req, 1'b0);
        checkOutput("stall_prio_valid", instr_valid, 1'b0);
        jump         = 1'b0;
        branch_taken = 1'b0;
        applyStimulus(1);
        checkOutput("stall_hold_pc", pc, 32'h80);
        checkOutput("stall_hold_req", imem_req, 1'b0);
        stall = 1'b0;
        applyStimulus(1);
        checkOutput("unstall_req", imem_req, 1'b1);
        checkOutput("unstall_addr", imem_addr, 32'h80);
        applyStimulus(1);
        checkOutput("unstall_valid", instr_valid, 1'b1);
        checkOutput("unstall_instr_pc", instr_pc, 32'h80);

        imem_ready = 1'b0;
        applyStimulus(1);
        branch_taken  = 1'b1;
        branch_target = 32'h300;
        applyStimulus(1);
        branch_taken = 1'b0;
        rst          = 1'b0;
        applyStimulus(1);
        checkOutput("midrst_pc", pc, 32'h0);
        checkOutput("midrst_req", imem_req, 1'b0);
        checkOutput("midrst_valid", instr_valid, 1'b0);
        checkOutput("midrst_instr_pc", instr_pc, 32'h0);
        rst        = 1'b1;
        imem_ready = 1'b1;
        applyStimulus(2);
        checkOutput("midrst_clean_valid", instr_valid, 1'b1);
        checkOutput("midrst_clean_instr_pc", instr_pc, 32'h0);
        checkOutput("midrst_clean_pc", pc, 32'h4);

        imem_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            applyStimulus(1);
            checkOutput("timeout_pending_req", imem_req, 1'b1);
            checkOutput("timeout_pending_err", timeout_err, 1'b0);
        end
        applyStimulus(1);
        checkOutput("timeout_err", timeout_err, 1'b1);
        checkOutput("timeout_req", imem_req, 1'b0);
        jump        = 1'b1;
        jump_target = 32'h500;
        stall       = 1'b1;
        imem_ready  = 1'b1;
        applyStimulus(2);
        checkOutput("error_pc_frozen", pc, 32'h4);
        checkOutput("error_sticky", timeout_err, 1'b1);
        checkOutput("error_req", imem_req, 1'b0);
        checkOutput("error_valid", instr_valid, 1'b0);
        jump  = 1'b0;
        stall = 1'b0;
        rst   = 1'b0;
        applyStimulus(1);
        checkOutput("error_cleared", timeout_err, 1'b0);
        checkOutput("error_cleared_pc", pc, 32'h0);

        rst_wrap = 1'b1;
        applyStimulus(1);
        checkOutput("wrap_start_pc", pc_wrap, 32'hFFFF_FFFC);
        checkOutput("wrap_start_addr", addr_wrap, 32'hFFFF_FFFC);
        applyStimulus(1);
        checkOutput("wrap_pc", pc_wrap, 32'h0);
        checkOutput("wrap_valid", valid_wrap, 1'b1);
        checkOutput("wrap_instr_pc", instr_pc_wrap, 32'hFFFF_FFFC);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
